reset_conditioner: RTL and testbench
====================================

RESET_CONDITIONER -- requirements
Module: reset_conditioner

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- SYNC_STAGES, 2: button synchroniser depth; minimum 2.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles before a button level is accepted; minimum 1.
- STRETCH_CYCLES, 16: cycles all outputs are held asserted after the cause clears; minimum 1.
- NUM_OUT, 4: number of reset output channels; minimum 1.
- RELEASE_GAP, 8: cycles between consecutive channel releases; minimum 1.
- CNT_W, 8: width of the event counter.
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clk, in, 1: single clock.
- rstn, in, 1: asynchronous, active-low global reset.
- i_btn_n, in, 1: raw asynchronous push-button, active-low.
- i_soft_rst, in, 1: synchronous one-cycle soft-reset request.
- o_rstn, out, NUM_OUT: conditioned active-low resets; deassertion is synchronous and sequenced.
- o_busy, out, 1: 1 while any o_rstn bit is 0.
- o_cause, out, 2: last reset cause; 00 = power-on, 01 = button, 10 = soft.
- o_count, out, CNT_W: saturating count of button and soft events.

Function
REQ-003 SHALL pass i_btn_n through SYNC_STAGES flops, all reset to 1, before any other use.
REQ-004 SHALL keep a debounced button level, reset to released. The level changes only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any intervening glitch restarts the count.
REQ-005 SHALL implement states HOLD, STRETCH, RELEASE and RUN; the reset state is HOLD.
REQ-006 In HOLD: all o_rstn bits are 0. Go to STRETCH on the first cycle the debounced level is released.
REQ-007 In STRETCH: all o_rstn bits are 0, for exactly STRETCH_CYCLES cycles, then go to RELEASE.
REQ-008 In RELEASE, on the first RELEASE cycle o_rstn[0] is 1. o_rstn[i] rises i*RELEASE_GAP cycles after o_rstn[0]. Bits, once high, stay high until the next event.
REQ-009 The state enters RUN in the cycle o_rstn[NUM_OUT-1] rises. With NUM_OUT=1 that is the same cycle o_rstn[0] rises.
REQ-010 In RUN: all o_rstn bits are 1.
- Debounced press: go to HOLD, o_cause=01.
- i_soft_rst=1: go to STRETCH with its counter restarted, o_cause=10.
- In both cases every o_rstn bit is 0 from the next cycle.
REQ-011 A debounced press in STRETCH or RELEASE SHALL go to HOLD; outputs reassert to 0 the next cycle.
REQ-012 i_soft_rst in STRETCH or RELEASE SHALL restart STRETCH and reassert all outputs. i_soft_rst in HOLD SHALL be ignored.
REQ-013 If a debounced press and i_soft_rst occur in the same cycle, the button SHALL win (HOLD, o_cause=01).
REQ-014 o_count SHALL increment by 1 on each accepted button or soft event, including restarts, and saturate at all-ones.
REQ-015 o_busy SHALL be 1 in every state except RUN.
REQ-016 All outputs and state SHALL be registered; no combinational path from i_btn_n or i_soft_rst to any output.

Reset
REQ-017 rstn low SHALL immediately and asynchronously set:
- state = HOLD, o_rstn = all 0, o_busy = 1;
- o_cause = 00, o_count = 0;
- synchroniser flops = 1, debounced level = released, all counters = 0.
REQ-018 Reset SHALL be released synchronously to clk. rstn asserted mid-sequence SHALL abort the sequence with no partial release.

Verification
Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STRETCH_CYCLES=3, NUM_OUT=3, RELEASE_GAP=2, CNT_W=2.
REQ-019 Power-on: rstn released, button idle, then observe o_rstn:
- 000 for 4 cycles (1 HOLD + 3 STRETCH);
- then 001, 2 cycles later 011, 2 cycles later 111;
- o_busy falls with the 111 cycle; o_cause=00, o_count=0.
REQ-020 Glitch reject: i_btn_n low for 3 cycles, then high -> no state change; o_count=0, o_rstn stays 111.
REQ-021 Button: i_btn_n low for 10 cycles, then high.
- o_rstn=000 starting 2 + 4 + 1 cycles after the falling edge; o_cause=01, o_count=1.
- Release follows debounced release with the REQ-019 pattern.
REQ-022 Soft during release: i_soft_rst pulse while o_rstn=011 -> next cycle o_rstn=000, full 3-cycle STRETCH restarts, o_cause=10, o_count increments.
REQ-023 Simultaneous and saturating: debounced press and i_soft_rst in the same RUN cycle -> HOLD, o_cause=01. Five events -> o_count=3, held there.
REQ-024 Mid-sequence reset: rstn pulsed low while o_rstn=001 -> o_rstn=000, o_count=0, o_cause=00 asynchronously; then the REQ-019 sequence repeats exactly.

Source files
------------

// File: rtl/reset_conditioner.sv
// Reset conditioner: debounces a push-button, stretches reset after the cause clears,
// then releases NUM_OUT active-low reset channels one after another.
module reset_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STRETCH_CYCLES  = 16,
    parameter int NUM_OUT         = 4,
    parameter int RELEASE_GAP     = 8,
    parameter int CNT_W           = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_btn_n,
    input  logic               i_soft_rst,
    output logic [NUM_OUT-1:0] o_rstn,
    output logic               o_busy,
    output logic [1:0]         o_cause,
    output logic [CNT_W-1:0]   o_count
);

    localparam int DB_W    = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam int ST_W    = (STRETCH_CYCLES < 2) ? 1 : $clog2(STRETCH_CYCLES);
    localparam int RL_SPAN = (NUM_OUT - 1) * RELEASE_GAP;
    localparam int RL_W    = (RL_SPAN < 2) ? 1 : $clog2(RL_SPAN + 1);

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST     = ST_W'(STRETCH_CYCLES - 1);
    localparam logic [RL_W-1:0] RL_PRE_LAST = RL_W'(RL_SPAN - 1);

    localparam logic [1:0] CAUSE_BUTTON = 2'b01;
    localparam logic [1:0] CAUSE_SOFT   = 2'b10;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic               level_q, level_d;   // debounced button, 1 = released
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic [ST_W-1:0]    st_cnt_q, st_cnt_d;
    logic [RL_W-1:0]    rl_cnt_q, rl_cnt_d;
    logic [NUM_OUT-1:0] rstn_q, rstn_d;
    logic               busy_q, busy_d;
    logic [1:0]         cause_q, cause_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [NUM_OUT-1:0] rel_mask;
    logic               btn_sync;
    logic               event_hit;

    assign btn_sync = sync_q[SYNC_STAGES-1];
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], i_btn_n};

    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        if (btn_sync != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = btn_sync;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        st_cnt_d  = st_cnt_q;
        rl_cnt_d  = rl_cnt_q;
        cause_d   = cause_q;
        count_d   = count_q;
        event_hit = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (level_q) begin
                    state_d  = ST_STRETCH;
                    st_cnt_d = '0;
                end
            end
            ST_STRETCH: begin
                if (st_cnt_q == ST_LAST) begin
                    rl_cnt_d = '0;
                    state_d  = (NUM_OUT == 1) ? ST_RUN : ST_RELEASE;
                end else begin
                    st_cnt_d = st_cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                rl_cnt_d = rl_cnt_q + 1'b1;
                if (rl_cnt_q == RL_PRE_LAST) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
            end
        endcase
        // A held press parks the FSM in HOLD, so the level test only fires once per press.
        if (state_q != ST_HOLD) begin
            if (!level_q) begin
                state_d   = ST_HOLD;
                cause_d   = CAUSE_BUTTON;
                event_hit = 1'b1;
            end else if (i_soft_rst) begin
                state_d   = ST_STRETCH;
                st_cnt_d  = '0;
                cause_d   = CAUSE_SOFT;
                event_hit = 1'b1;
            end
        end
        if (event_hit && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_rel
            if (gi == 0) begin : g_first
                assign rel_mask[gi] = 1'b1;
            end else begin : g_rest
                assign rel_mask[gi] = (rl_cnt_d >= RL_W'(gi * RELEASE_GAP));
            end
        end
    endgenerate

    always_comb begin
        rstn_d = '0;
        if (state_d == ST_RUN) begin
            rstn_d = '1;
        end else if (state_d == ST_RELEASE) begin
            rstn_d = rel_mask;
        end
        busy_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_HOLD;
            sync_q   <= '1;
            level_q  <= 1'b1;
            db_cnt_q <= '0;
            st_cnt_q <= '0;
            rl_cnt_q <= '0;
            rstn_q   <= '0;
            busy_q   <= 1'b1;
            cause_q  <= 2'b00;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
            st_cnt_q <= st_cnt_d;
            rl_cnt_q <= rl_cnt_d;
            rstn_q   <= rstn_d;
            busy_q   <= busy_d;
            cause_q  <= cause_d;
            count_q  <= count_d;
        end
    end

    assign o_rstn  = rstn_q;
    assign o_busy  = busy_q;
    assign o_cause = cause_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_reset_conditioner.sv
// Directed bench for reset_conditioner: power-on, glitch, button, soft restart,
// simultaneous/saturating events and mid-sequence asynchronous reset.
module tb_reset_conditioner;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       i_btn_n = 1'b1;
    logic       i_soft_rst = 1'b0;
    logic [2:0] o_rstn;
    logic       o_busy;
    logic [1:0] o_cause;
    logic [1:0] o_count;

    int tests_run = 0;
    int tests_failed = 0;

    // Release pattern starting with the first STRETCH cycle.
    logic [2:0] exp_seq [8];

    always #5 clk = ~clk;

    reset_conditioner #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .STRETCH_CYCLES(3),
        .NUM_OUT(3),
        .RELEASE_GAP(2),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .i_btn_n(i_btn_n),
        .i_soft_rst(i_soft_rst),
        .o_rstn(o_rstn),
        .o_busy(o_busy),
        .o_cause(o_cause),
        .o_count(o_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (o_rstn !== 3'b000 || o_busy !== 1'b1 || o_cause !== 2'b00 || o_count !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_state: got rstn=%b busy=%b cause=%b count=%0d want 000 1 00 0",
                     o_rstn, o_busy, o_cause, o_count);
        end
        rstn = 1'b1;
        tests_run++;
        if (o_rstn !== 3'b000) begin
            tests_failed++;
            $display("FAIL poweron_hold: got %b want 000", o_rstn);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            tests_run++;
            if (o_rstn !== exp_seq[k] || o_busy !== (k != 7)) begin
                tests_failed++;
                $display("FAIL poweron_seq step %0d: got rstn=%b busy=%b want %b %b",
                         k, o_rstn, o_busy, exp_seq[k], (k != 7));
            end
        end
        tests_run++;
        if (o_cause !== 2'b00 || o_count !== 2'b00) begin
            tests_failed++;
            $display("FAIL poweron_cause: got cause=%b count=%0d want 00 0", o_cause, o_count);
        end
        $display("[TB] power-on sequence done");
    endtask

    task automatic test_glitch();
        i_btn_n = 1'b0;
        repeat (3) tick();
        i_btn_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            tests_run++;
            if (o_rstn !== 3'b111 || o_busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL glitch_rstn cycle %0d: got rstn=%b busy=%b want 111 0", k, o_rstn, o_busy);
            end
        end
        tests_run++;
        if (o_count !== 2'b00 || o_cause !== 2'b00) begin
            tests_failed++;
            $display("FAIL glitch_count: got count=%0d cause=%b want 0 00", o_count, o_cause);
        end
        $display("[TB] 3-cycle glitch rejected");
    endtask

    task automatic test_button();
        logic [2:0] exp;
        i_btn_n = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp = (k >= 7) ? 3'b000 : 3'b111;
            tests_run++;
            if (o_rstn !== exp) begin
                tests_failed++;
                $display("FAIL button_press cycle %0d: got %b want %b", k, o_rstn, exp);
            end
            if (k == 7) begin
                tests_run++;
                if (o_cause !== 2'b01 || o_count !== 2'd1) begin
                    tests_failed++;
                    $display("FAIL button_cause: got cause=%b count=%0d want 01 1", o_cause, o_count);
                end
            end
        end
        i_btn_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp = (k < 7) ? 3'b000 : exp_seq[k-7];
            tests_run++;
            if (o_rstn !== exp) begin
                tests_failed++;
                $display("FAIL button_release cycle %0d: got %b want %b", k, o_rstn, exp);
            end
        end
        tests_run++;
        if (o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL button_busy: got %b want 0", o_busy);
        end
        $display("[TB] button press/release done");
    endtask

    task automatic test_soft_release();
        i_soft_rst = 1'b1;
        tick();
        i_soft_rst = 1'b0;
        tests_run++;
        if (o_rstn !== 3'b000 || o_cause !== 2'b10 || o_count !== 2'd2) begin
            tests_failed++;
            $display("FAIL soft_run: got rstn=%b cause=%b count=%0d want 000 10 2", o_rstn, o_cause, o_count);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            tests_run++;
            if (o_rstn !== exp_seq[k]) begin
                tests_failed++;
                $display("FAIL soft_seq step %0d: got %b want %b", k, o_rstn, exp_seq[k]);
            end
        end
        i_soft_rst = 1'b1;
        tick();
        i_soft_rst = 1'b0;
        tests_run++;
        if (o_rstn !== 3'b000 || o_cause !== 2'b10 || o_count !== 2'd3) begin
            tests_failed++;
            $display("FAIL soft_restart: got rstn=%b cause=%b count=%0d want 000 10 3", o_rstn, o_cause, o_count);
        end
        for (int k = 1; k < 8; k++) begin
            tick();
            tests_run++;
            if (o_rstn !== exp_seq[k]) begin
                tests_failed++;
                $display("FAIL soft_restart_seq step %0d: got %b want %b", k, o_rstn, exp_seq[k]);
            end
        end
        $display("[TB] soft restart during release done");
    endtask

    task automatic test_simultaneous();
        i_btn_n = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            tests_run++;
            if (o_rstn !== 3'b111) begin
                tests_failed++;
                $display("FAIL simul_pre cycle %0d: got %b want 111", k, o_rstn);
            end
        end
        i_soft_rst = 1'b1;
        tick();
        i_soft_rst = 1'b0;
        tests_run++;
        if (o_rstn !== 3'b000 || o_cause !== 2'b01 || o_count !== 2'd3) begin
            tests_failed++;
            $display("FAIL simul_button_wins: got rstn=%b cause=%b count=%0d want 000 01 3",
                     o_rstn, o_cause, o_count);
        end
        i_soft_rst = 1'b1;
        tick();
        i_soft_rst = 1'b0;
        tick();
        tests_run++;
        if (o_cause !== 2'b01 || o_rstn !== 3'b000) begin
            tests_failed++;
            $display("FAIL hold_ignores_soft: got cause=%b rstn=%b want 01 000", o_cause, o_rstn);
        end
        tick();
        i_btn_n = 1'b1;
        for (int i = 0; i < 40 && o_rstn !== 3'b111; i++) tick();
        tests_run++;
        if (o_rstn !== 3'b111) begin
            tests_failed++;
            $display("FAIL simul_rerun timeout: got %b want 111", o_rstn);
        end
        i_soft_rst = 1'b1;
        tick();
        i_soft_rst = 1'b0;
        tests_run++;
        if (o_count !== 2'd3 || o_cause !== 2'b10 || o_rstn !== 3'b000) begin
            tests_failed++;
            $display("FAIL saturate: got count=%0d cause=%b rstn=%b want 3 10 000", o_count, o_cause, o_rstn);
        end
        $display("[TB] simultaneous and saturation done");
    endtask

    task automatic test_mid_reset();
        repeat (3) tick();
        tests_run++;
        if (o_rstn !== 3'b001) begin
            tests_failed++;
            $display("FAIL mid_pre: got %b want 001", o_rstn);
        end
        rstn = 1'b0;
        #1;
        tests_run++;
        if (o_rstn !== 3'b000 || o_count !== 2'd0 || o_cause !== 2'b00 || o_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_async: got rstn=%b count=%0d cause=%b busy=%b want 000 0 00 1",
                     o_rstn, o_count, o_cause, o_busy);
        end
        repeat (2) tick();
        rstn = 1'b1;
        tests_run++;
        if (o_rstn !== 3'b000) begin
            tests_failed++;
            $display("FAIL mid_hold: got %b want 000", o_rstn);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            tests_run++;
            if (o_rstn !== exp_seq[k] || o_busy !== (k != 7)) begin
                tests_failed++;
                $display("FAIL mid_seq step %0d: got rstn=%b busy=%b want %b %b",
                         k, o_rstn, o_busy, exp_seq[k], (k != 7));
            end
        end
        $display("[TB] mid-sequence reset done");
    endtask

    initial begin
        exp_seq = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b011, 3'b011, 3'b111};
        test_reset();
        test_glitch();
        test_button();
        test_soft_release();
        test_simultaneous();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
